// File: rtl/pavana_slave_ram.sv
// Crossbar slave endpoint: single-port word RAM with req/ack handshake, in-order read pipeline
// and programmable ack wait states. Define PAVANA_SLAVE_RAM_STALL_EN for LFSR-driven ack stalls.
module pavana_slave_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned ACK_WAIT   = 0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        cmd,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        resp
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_INIT = (ACK_WAIT > 0) ? ACK_WAIT - 1 : 0;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [RD_LATENCY-1:0]                vld_q, vld_d;
  logic [RD_LATENCY-1:0][DATA_W-1:0]    dat_q, dat_d;
  logic [DATA_W-1:0]                    mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]                word_c;
  logic                                 stall_c;
  logic                                 ack_c;
  logic                                 rd_acc_c;
  logic                                 wr_acc_c;
  logic                                 unused_addr_c;

  assign word_c        = addr[ADDR_WIDTH+1:2];
  assign unused_addr_c = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

`ifdef PAVANA_SLAVE_RAM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; bit 0 vetoes ack
  always_comb begin : lfsr_next
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_c = lfsr_q[0];
`else
  logic unused_seed_c;
  assign unused_seed_c = ^STALL_SEED;
  assign stall_c       = 1'b0;
`endif

  // Ack generation: pass-through without wait states, else IDLE/WAIT countdown
  always_comb begin : ack_fsm
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_c   = 1'b0;
    if (ACK_WAIT == 0) begin
      ack_c = req & ~stall_c;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cnt_d   = CNT_W'(CNT_INIT);
            state_d = WAIT;
          end
        end
        WAIT: begin
          ack_c = req & (cnt_q == '0) & ~stall_c;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (!req || ack_c) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (rst_i) begin
      ack_c = 1'b0;
    end
  end

  assign rd_acc_c = ack_c & ~cmd;
  assign wr_acc_c = ack_c & cmd;

  // Read shift pipeline; data is zeroed in empty slots so rdata idles at 0
  always_comb begin : rd_pipe
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc_c;
    dat_d[0] = rd_acc_c ? mem_q[word_c] : '0;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_acc_c) begin
      mem_q[word_c] <= wdata;
    end
  end

  assign ack   = ack_c;
  assign resp  = vld_q[RD_LATENCY-1];
  assign rdata = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_pavana_slave_ram.sv
// Bench for pavana_slave_ram: three instances (lat 2/ws 0, lat 3/ws 0, lat 4/ws 3) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_pavana_slave_ram;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst   [NI];
  logic        req   [NI];
  logic [31:0] addr  [NI];
  logic        cmd   [NI];
  logic [31:0] wdata [NI];
  logic        ack   [NI];
  logic [31:0] rdata [NI];
  logic        resp  [NI];

  int   checks;
  int   errors;
  int   cyc;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pavana_slave_ram #(
      .ADDR_WIDTH (10),
      .RD_LATENCY ((g == 0) ? 2 : (g == 1) ? 3 : 4),
      .ACK_WAIT   ((g == 2) ? 3 : 0),
      .STALL_SEED (16'h0001)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst[g]),
      .req   (req[g]),
      .addr  (addr[g]),
      .cmd   (cmd[g]),
      .wdata (wdata[g]),
      .ack   (ack[g]),
      .rdata (rdata[g]),
      .resp  (resp[g])
    );
  end

  function automatic int lat(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 4;
  endfunction

  function automatic int aw(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Reference model: RAM array, response queue with due cycles, per-request wait counter
  logic [31:0] mem_m  [NI][1024];
  exp_t        q_m    [$];
  int          wcnt_m [NI];
  bit          en_m   [NI];
  logic [15:0] lfsr_m [NI];

  initial begin
    logic e_ack;
    logic stall;
    int   h;
    for (int i = 0; i < NI; i++) begin
      en_m[i]   = 1'b0;
      wcnt_m[i] = 0;
      lfsr_m[i] = 16'h0001;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        e_ack = 1'b0;
`ifdef PAVANA_SLAVE_RAM_STALL_EN
        stall = lfsr_m[i][0];
`else
        stall = 1'b0;
`endif
        if (en_m[i]) begin
          e_ack = !rst[i] && req[i] && (wcnt_m[i] >= aw(i)) && !stall;
          chk("ack", 32'(ack[i]), 32'(e_ack));
          h = -1;
          for (int j = 0; j < q_m.size(); j++) begin
            if (h < 0 && q_m[j].inst == i) h = j;
          end
          if (h >= 0 && q_m[h].due == cyc) begin
            chk("resp", 32'(resp[i]), 32'd1);
            chk("rdata", rdata[i], q_m[h].data);
            q_m.delete(h);
          end else begin
            chk("resp_idle", 32'(resp[i]), 32'd0);
            chk("rdata_idle", rdata[i], 32'd0);
          end
        end
        if (rst[i]) begin
          for (int j = q_m.size() - 1; j >= 0; j--) begin
            if (q_m[j].inst == i) q_m.delete(j);
          end
          wcnt_m[i] = 0;
          lfsr_m[i] = 16'h0001;
          en_m[i]   = 1'b1;
        end else begin
          if (e_ack) begin
            if (cmd[i]) mem_m[i][(addr[i] >> 2) & 32'd1023] = wdata[i];
            else q_m.push_back('{i, cyc + lat(i), mem_m[i][(addr[i] >> 2) & 32'd1023]});
            wcnt_m[i] = 0;
          end else if (req[i]) begin
            wcnt_m[i]++;
          end else begin
            wcnt_m[i] = 0;
          end
          lfsr_m[i] = {lfsr_m[i][14:0],
                       lfsr_m[i][15] ^ lfsr_m[i][13] ^ lfsr_m[i][12] ^ lfsr_m[i][10]};
        end
      end
    end
  end

  // Issue one request and hold it until acked; returns the number of unacked cycles
  task automatic do_op(input int i, input logic c, input logic [31:0] a,
                       input logic [31:0] d, output int waits);
    req[i]   = 1'b1;
    cmd[i]   = c;
    addr[i]  = a;
    wdata[i] = d;
    waits    = 0;
    @(negedge clk);
    while (!ack[i] && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    if (!ack[i]) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout inst %0d: no ack after %0d cycles, expected ack", i, waits);
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  int          w;
  int          wd;
  logic [31:0] a;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NI; i++) begin
      rst[i]   = 1'b1;
      req[i]   = 1'b0;
      addr[i]  = '0;
      cmd[i]   = 1'b0;
      wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    // Reset values with req low
    @(negedge clk);
    chk("reset_ack", 32'(ack[0]), 32'd0);
    chk("reset_resp", 32'(resp[0]), 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    @(posedge clk);
    #1;

    // Write then read the same word next cycle
    do_op(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, w);
`ifndef PAVANA_SLAVE_RAM_STALL_EN
    chk("wr_ack_immediate", 32'(w), 32'd0);
`endif
    do_op(0, 1'b0, 32'h0000_0010, 32'h0, w);
`ifndef PAVANA_SLAVE_RAM_STALL_EN
    chk("rd_ack_immediate", 32'(w), 32'd0);
`endif
    @(negedge clk);
    chk("raw_resp_early", 32'(resp[0]), 32'd0);
    @(negedge clk);
    chk("raw_resp", 32'(resp[0]), 32'd1);
    chk("raw_rdata", rdata[0], 32'hDEAD_BEEF);
    @(posedge clk);
    #1;

    // Upper address bits alias onto word 4
    do_op(0, 1'b0, 32'hFFFF_F010, 32'h0, w);
    @(negedge clk);
    @(negedge clk);
    chk("alias_rdata", rdata[0], 32'hDEAD_BEEF);
    @(posedge clk);
    #1;

    // Back-to-back reads at latency 3
    for (int k = 0; k < 4; k++) do_op(1, 1'b1, 32'(k * 4), 32'(32'h10 + k), w);
`ifndef PAVANA_SLAVE_RAM_STALL_EN
    fork
      begin
        for (int k = 0; k < 4; k++) do_op(1, 1'b0, 32'(k * 4), 32'h0, w);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("b2b_resp", 32'(resp[1]), 32'd1);
          chk("b2b_rdata", rdata[1], 32'(32'h10 + k));
        end
        @(negedge clk);
        chk("b2b_resp_end", 32'(resp[1]), 32'd0);
      end
    join
`else
    for (int k = 0; k < 4; k++) do_op(1, 1'b0, 32'(k * 4), 32'h0, w);
`endif
    @(posedge clk);
    #1;

    // Three wait states per request
    do_op(2, 1'b1, 32'h0000_0040, 32'hCAFE_0001, w);
`ifndef PAVANA_SLAVE_RAM_STALL_EN
    chk("ws_first", 32'(w), 32'd3);
`endif
    do_op(2, 1'b1, 32'h0000_0044, 32'hCAFE_0002, w);
`ifndef PAVANA_SLAVE_RAM_STALL_EN
    chk("ws_second", 32'(w), 32'd3);
`endif

    // Reset pulse kills an in-flight read
    do_op(2, 1'b0, 32'h0000_0040, 32'h0, w);
    rst[2] = 1'b1;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("flushed_resp", 32'(resp[2]), 32'd0);
    end
    @(posedge clk);
    #1;
    do_op(2, 1'b0, 32'h0000_0044, 32'h0, w);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("post_reset_resp", 32'(resp[2]), 32'd1);
    chk("post_reset_rdata", rdata[2], 32'hCAFE_0002);
    @(posedge clk);
    #1;

    // Random traffic over 16 words with aliased upper bits
    for (int k = 0; k < 16; k++) do_op(0, 1'b1, 32'(k * 4), $urandom(), w);
    for (int n = 0; n < 200; n++) begin
      wd = int'($urandom_range(0, 15));
      a  = ($urandom() & 32'hFFFF_F003) | 32'(wd * 4);
      do_op(0, 1'($urandom_range(0, 1)), a, $urandom(), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 16; k++) do_op(2, 1'b1, 32'(k * 4), $urandom(), w);
    for (int n = 0; n < 40; n++) begin
      wd = int'($urandom_range(0, 15));
      a  = ($urandom() & 32'hFFFF_F003) | 32'(wd * 4);
      do_op(2, 1'($urandom_range(0, 1)), a, $urandom(), w);
    end

    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
